// File: rtl/rect_fill_engine.sv
// Rectangle / full-screen fill pixel generator feeding the framebuffer writer, one pixel per cycle in raster order.
// Latency: first pixel one cycle after accept, done one cycle after the last pixel; requests wait while not idle.
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic       clear_req,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [7:0] req_w,
    input  logic [6:0] req_h,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    localparam logic [8:0] SW9 = 9'(SCREEN_W);
    localparam logic [7:0] SH8 = 8'(SCREEN_H);
    localparam logic [7:0] SW8 = 8'(SCREEN_W);
    localparam logic [6:0] SH7 = 7'(SCREEN_H);

    state_t     state_q, state_d;
    logic [7:0] x0_q, x0_d, w_q, w_d, col_q, col_d;
    logic [6:0] y0_q, y0_d, h_q, h_d, row_q, row_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, done_q, done_d;

    logic       load_pix;
    logic [7:0] pix_x0, pix_col;
    logic [6:0] pix_y0, pix_row;
    logic [2:0] pix_colour;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        fill_d     = fill_q;
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        load_pix   = 1'b0;
        pix_x0     = x0_q;
        pix_y0     = y0_q;
        pix_col    = 8'd0;
        pix_row    = 7'd0;
        pix_colour = fill_q;

        case (state_q)
            S_IDLE: begin
                if (clear_req || req_valid) begin
                    x0_d   = clear_req ? 8'd0 : req_x;
                    y0_d   = clear_req ? 7'd0 : req_y;
                    w_d    = clear_req ? SW8  : req_w;
                    h_d    = clear_req ? SH7  : req_h;
                    fill_d = req_colour;
                    col_d  = 8'd0;
                    row_d  = 7'd0;
                    if (w_d == 8'd0 || h_d == 7'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Register pixel 0 on the accept edge so it is visible the very next cycle.
                        state_d    = S_DRAW;
                        load_pix   = 1'b1;
                        pix_x0     = x0_d;
                        pix_y0     = y0_d;
                        pix_colour = fill_d;
                    end
                end
            end
            S_DRAW: begin
                if (col_q == w_q - 8'd1 && row_q == h_q - 7'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (col_q == w_q - 8'd1) begin
                        col_d = 8'd0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    load_pix = 1'b1;
                    pix_col  = col_d;
                    pix_row  = row_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Sums stay one bit wider than the operands so off-screen pixels are never aliased on-screen.
        sum_x = {1'b0, pix_x0} + {1'b0, pix_col};
        sum_y = {1'b0, pix_y0} + {1'b0, pix_row};
        if (load_pix) begin
            x_d      = sum_x[7:0];
            y_d      = sum_y[6:0];
            colour_d = pix_colour;
            plot_d   = (sum_x < SW9) && (sum_y < SH8);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            x0_q     <= 8'd0;
            y0_q     <= 7'd0;
            w_q      <= 8'd0;
            h_q      <= 7'd0;
            fill_q   <= 3'd0;
            col_q    <= 8'd0;
            row_q    <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            fill_q   <= fill_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;

endmodule
